// File: rtl/isop_mux_sched_if.sv
// ---------------------------------------------------------------------------
// isop_mux_sched_if
//   Bundles the sample-side and result-side signals of isop_mux_sched.
//   master : producer of samples / consumer of results (decimators + half-band)
//   slave  : the scheduler itself
//
//   nd       NCH      per-channel one-cycle sample strobe
//   din      NCH*IW   packed per-channel signed samples, channel i at [i*IW +: IW]
//   out_vld  1        one-cycle result strobe
//   out_ch   3        channel index of the current result
//   out_dat  OW       signed ISOP result
//   busy     1        scheduler FSM is not idle
//   ovr      NCH      sticky per-channel overrun flags
// ---------------------------------------------------------------------------
interface isop_mux_sched_if #(
    parameter int NCH = 4,
    parameter int IW  = 44,
    parameter int OW  = 47
);
    logic [NCH-1:0]    nd;
    logic [NCH*IW-1:0] din;
    logic              out_vld;
    logic [2:0]        out_ch;
    logic [OW-1:0]     out_dat;
    logic              busy;
    logic [NCH-1:0]    ovr;

    modport master (
        output nd, din,
        input  out_vld, out_ch, out_dat, busy, ovr
    );

    modport slave (
        input  nd, din,
        output out_vld, out_ch, out_dat, busy, ovr
    );
endinterface

// File: rtl/isop_mux_sched.sv
// ---------------------------------------------------------------------------
// isop_mux_sched
//   Shares one multi-cycle ISOP compensator, y = (x + C*d1 + d2) >>> 2,
//   between NCH decimated CIC channels. Incoming samples are parked in a
//   per-channel holding register, granted round-robin to the datapath, and
//   each channel keeps its own two-sample delay line (d1, d2).
//
//   clk     in   system clock, all logic on the rising edge
//   rst     in   synchronous active-low reset
//   io_bus  slave modport of isop_mux_sched_if (nd/din in, results/flags out)
//
//   Service takes four edges: IDLE(grant) -> MUL -> SUM -> WB -> IDLE.
// ---------------------------------------------------------------------------
module isop_mux_sched #(
    parameter int NCH = 4,
    parameter int IW  = 44,
    parameter int OW  = 47,
    parameter int C   = -6
) (
    input  logic                clk,
    input  logic                rst,
    isop_mux_sched_if.slave     io_bus
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW = IW + 4;   // C*d1 product width
    localparam int SW = IW + 5;   // x + C*d1 + d2 sum width, cannot overflow

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_SUM  = 2'd2;
    localparam logic [1:0] ST_WB   = 2'd3;

    localparam logic signed [PW-1:0] C_EXT = PW'(C);

    logic [1:0]           r_state;
    logic [NCH-1:0]       r_pending;
    logic [NCH-1:0]       r_ovr;
    logic signed [IW-1:0] r_hold [NCH];
    logic signed [IW-1:0] r_d1   [NCH];
    logic signed [IW-1:0] r_d2   [NCH];
    logic [CW-1:0]        r_last;
    logic [CW-1:0]        r_cur;
    logic signed [IW-1:0] r_x;
    logic signed [PW-1:0] r_p;
    logic signed [SW-1:0] r_s;
    logic                 r_out_vld;
    logic [2:0]           r_out_ch;
    logic [OW-1:0]        r_out_dat;

    logic [CW-1:0]        w_gnt;
    logic                 w_gnt_vld;
    logic                 w_take;

    // Channel index 'offs' positions after 'last', wrapping at NCH.
    function automatic logic [CW-1:0] rr_index(input logic [CW-1:0] last, input int offs);
        int idx;
        idx = int'(last) + offs;
        if (idx >= NCH) idx = idx - NCH;
        return idx[CW-1:0];
    endfunction

    // Round-robin arbiter. Scanning from the farthest candidate back to the
    // nearest lets the first pending channel after r_last win.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        w_gnt     = '0;
        w_gnt_vld = 1'b0;
        for (int k = NCH; k >= 1; k--) begin
            if (r_pending[rr_index(r_last, k)]) begin
                w_gnt     = rr_index(r_last, k);
                w_gnt_vld = 1'b1;
            end
        end
    end

    assign w_take = (r_state == ST_IDLE) && w_gnt_vld;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_ovr     <= '0;
            r_last    <= CW'(NCH - 1);
            r_cur     <= '0;
            r_x       <= '0;
            r_p       <= '0;
            r_s       <= '0;
            r_out_vld <= 1'b0;
            r_out_ch  <= '0;
            r_out_dat <= '0;
            // NOTE: the delay lines and holding registers are architectural
            // state, so they are cleared here rather than left to power-up.
            for (int i = 0; i < NCH; i++) begin
                r_hold[i] <= '0;
                r_d1[i]   <= '0;
                r_d2[i]   <= '0;
            end
        end else begin
            r_out_vld <= 1'b0;

            // Sample capture. A channel granted at this edge frees its slot,
            // so a coincident strobe refills it instead of counting as overrun.
            // NOTE: non-blocking assignment means r_x below still picks up the
            // old r_hold value even when the slot is refilled at the same edge.
            for (int i = 0; i < NCH; i++) begin
                if (io_bus.nd[i]) begin
                    if (!r_pending[i] || (w_take && (w_gnt == CW'(i)))) begin
                        r_hold[i]    <= io_bus.din[i*IW +: IW];
                        r_pending[i] <= 1'b1;
                    end else begin
                        r_ovr[i]     <= 1'b1;
                    end
                end else if (w_take && (w_gnt == CW'(i))) begin
                    r_pending[i] <= 1'b0;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_vld) begin
                        r_x     <= r_hold[w_gnt];
                        r_cur   <= w_gnt;
                        r_last  <= w_gnt;
                        r_state <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    r_p     <= C_EXT * PW'(r_d1[r_cur]);
                    r_state <= ST_SUM;
                end
                ST_SUM: begin
                    r_s     <= SW'(r_x) + SW'(r_p) + SW'(r_d2[r_cur]);
                    r_state <= ST_WB;
                end
                ST_WB: begin
                    // Arithmetic shift floors toward -inf.
                    r_out_dat   <= OW'(r_s >>> 2);
                    r_out_ch    <= 3'(r_cur);
                    r_out_vld   <= 1'b1;
                    r_d2[r_cur] <= r_d1[r_cur];
                    r_d1[r_cur] <= r_x;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign io_bus.out_vld = r_out_vld;
    assign io_bus.out_ch  = r_out_ch;
    assign io_bus.out_dat = r_out_dat;
    assign io_bus.busy    = (r_state != ST_IDLE);
    assign io_bus.ovr     = r_ovr;

endmodule

// File: tb/tb_isop_mux_sched.sv
// ---------------------------------------------------------------------------
// tb_isop_mux_sched
//   Directed bench for isop_mux_sched (NCH=4, IW=44, OW=47, C=-6).
//   Inputs change 1 time unit after a rising edge; outputs are sampled on
//   the falling edge. A monitor logs every out_vld cycle with the edge count
//   at which it was registered, and each scenario task compares that log
//   against hand-computed values.
// ---------------------------------------------------------------------------
module tb_isop_mux_sched;

    localparam int NCH = 4;
    localparam int IW  = 44;
    localparam int OW  = 47;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    isop_mux_sched_if #(.NCH(NCH), .IW(IW), .OW(OW)) bus ();

    isop_mux_sched #(.NCH(NCH), .IW(IW), .OW(OW), .C(-6)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    typedef struct {
        int unsigned   edge_no;
        logic [2:0]    ch;
        logic [OW-1:0] dat;
    } res_t;

    res_t        res_q[$];
    int unsigned edge_cnt = 0;
    int          n_vec    = 0;
    int          n_miss   = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(negedge clk) begin
        if (bus.out_vld === 1'b1)
            res_q.push_back('{edge_no: edge_cnt, ch: bus.out_ch, dat: bus.out_dat});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int ch, input longint v);
        bus.din[ch*IW +: IW] = v[IW-1:0];
    endtask

    task automatic apply_reset();
        bus.nd = '0;
        rst    = 1'b0;
        tick();
        tick();
        rst    = 1'b1;
        res_q.delete();
    endtask

    // Waits (bounded) for n results, then a few idle cycles so a stray
    // extra result would also show up in the log.
    task automatic wait_results(input int n, output bit ok);
        int c;
        c = 0;
        while (res_q.size() < n && c < 400) begin
            tick();
            c++;
        end
        repeat (6) tick();
        ok = (res_q.size() == n);
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_vec++;
        if ({bus.out_vld, bus.out_ch, bus.out_dat, bus.busy} !== '0) begin
            n_miss++;
            $display("FAIL reset_outputs: vld=%b ch=%0d dat=%0d busy=%b, want all 0",
                     bus.out_vld, bus.out_ch, $signed(bus.out_dat), bus.busy);
        end
        n_vec++;
        if (bus.ovr !== 4'b0000) begin
            n_miss++;
            $display("FAIL reset_ovr: got %b want 0000", bus.ovr);
        end
    endtask

    task automatic test_impulse();
        longint      xin[4]  = '{4, 0, 0, 0};
        longint      expd[4] = '{1, -6, 1, 0};
        int unsigned e0[4];
        bit          ok;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            set_lane(0, xin[k]);
            bus.nd = 4'b0001;
            tick();
            e0[k] = edge_cnt;
            bus.nd = '0;
            repeat (7) tick();
        end
        wait_results(4, ok);
        n_vec++;
        if (!ok) begin
            n_miss++;
            $display("FAIL impulse_count: got %0d results want 4", res_q.size());
        end
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (k >= res_q.size()) begin
                n_miss++;
                $display("FAIL impulse[%0d]: no result, want ch0 dat %0d", k, expd[k]);
            end else if (res_q[k].ch !== 3'd0 || res_q[k].dat !== OW'(expd[k]) ||
                         res_q[k].edge_no != e0[k] + 4) begin
                n_miss++;
                $display("FAIL impulse[%0d]: got ch%0d dat %0d @E+%0d, want ch0 dat %0d @E+4",
                         k, res_q[k].ch, $signed(res_q[k].dat), res_q[k].edge_no - e0[k], expd[k]);
            end
        end
    endtask

    task automatic test_simultaneous();
        longint      expd[4] = '{2, 5, 7, 10};
        int unsigned e0;
        bit          exp_busy;
        bit          ok;
        apply_reset();
        for (int i = 0; i < NCH; i++) set_lane(i, 10 * (i + 1));
        bus.nd = 4'b1111;
        tick();
        e0 = edge_cnt;
        bus.nd = '0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            @(negedge clk);
            exp_busy = (k % 4 != 0);
            n_vec++;
            if (bus.busy !== exp_busy) begin
                n_miss++;
                $display("FAIL simul_busy after E%0d: got %b want %b", k, bus.busy, exp_busy);
            end
        end
        wait_results(4, ok);
        n_vec++;
        if (!ok) begin
            n_miss++;
            $display("FAIL simul_count: got %0d results want 4", res_q.size());
        end
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (k >= res_q.size()) begin
                n_miss++;
                $display("FAIL simul[%0d]: no result, want ch%0d dat %0d", k, k, expd[k]);
            end else if (res_q[k].ch !== 3'(k) || res_q[k].dat !== OW'(expd[k]) ||
                         res_q[k].edge_no != e0 + 4 * (k + 1)) begin
                n_miss++;
                $display("FAIL simul[%0d]: got ch%0d dat %0d @E+%0d, want ch%0d dat %0d @E+%0d",
                         k, res_q[k].ch, $signed(res_q[k].dat), res_q[k].edge_no - e0,
                         k, expd[k], 4 * (k + 1));
            end
        end
    endtask

    task automatic test_overrun();
        int unsigned e0;
        bit          ok;
        apply_reset();
        for (int i = 0; i < NCH; i++) set_lane(i, 4 * (i + 1));
        bus.nd = 4'b1111;
        tick();
        e0 = edge_cnt;
        set_lane(1, 100);
        bus.nd = 4'b0010;
        tick();
        bus.nd = '0;
        @(negedge clk);
        n_vec++;
        if (bus.ovr !== 4'b0010) begin
            n_miss++;
            $display("FAIL overrun_flag: got %b want 0010", bus.ovr);
        end
        wait_results(4, ok);
        n_vec++;
        if (!ok) begin
            n_miss++;
            $display("FAIL overrun_count: got %0d results want 4", res_q.size());
        end
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (k >= res_q.size()) begin
                n_miss++;
                $display("FAIL overrun[%0d]: no result, want ch%0d dat %0d", k, k, k + 1);
            end else if (res_q[k].ch !== 3'(k) || res_q[k].dat !== OW'(k + 1) ||
                         res_q[k].edge_no != e0 + 4 * (k + 1)) begin
                n_miss++;
                $display("FAIL overrun[%0d]: got ch%0d dat %0d @E+%0d, want ch%0d dat %0d @E+%0d",
                         k, res_q[k].ch, $signed(res_q[k].dat), res_q[k].edge_no - e0,
                         k, k + 1, 4 * (k + 1));
            end
        end
    endtask

    // Runs straight after test_overrun: ovr=0010, out_ch=3, out_dat=4 and
    // ch2's d1=12 are all nonzero going in, so the reset has work to do.
    task automatic test_reset_mid_op();
        int unsigned e0;
        bit          ok;
        res_q.delete();
        set_lane(2, 400);
        bus.nd = 4'b0100;
        tick();
        bus.nd = '0;
        tick();
        tick();
        @(negedge clk);
        n_vec++;
        if (bus.busy !== 1'b1) begin
            n_miss++;
            $display("FAIL midrst_inflight_busy: got %b want 1", bus.busy);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({bus.out_vld, bus.out_ch, bus.out_dat, bus.busy} !== '0) begin
            n_miss++;
            $display("FAIL midrst_outputs: vld=%b ch=%0d dat=%0d busy=%b, want all 0",
                     bus.out_vld, bus.out_ch, $signed(bus.out_dat), bus.busy);
        end
        n_vec++;
        if (bus.ovr !== 4'b0000) begin
            n_miss++;
            $display("FAIL midrst_ovr: got %b want 0000", bus.ovr);
        end
        repeat (8) tick();
        n_vec++;
        if (res_q.size() != 0) begin
            n_miss++;
            $display("FAIL midrst_discard: got %0d results want 0", res_q.size());
        end
        res_q.delete();
        set_lane(2, 4);
        bus.nd = 4'b0100;
        tick();
        e0 = edge_cnt;
        bus.nd = '0;
        wait_results(1, ok);
        n_vec++;
        if (!ok || res_q[0].ch !== 3'd2 || res_q[0].dat !== OW'(1) || res_q[0].edge_no != e0 + 4) begin
            n_miss++;
            if (res_q.size() == 0)
                $display("FAIL midrst_restart: no result, want ch2 dat 1");
            else
                $display("FAIL midrst_restart: got ch%0d dat %0d @E+%0d (n=%0d), want ch2 dat 1 @E+4",
                         res_q[0].ch, $signed(res_q[0].dat), res_q[0].edge_no - e0, res_q.size());
        end
    endtask

    task automatic test_grant_collision();
        longint      expd[2] = '{1, -4};
        int unsigned e0;
        bit          ok;
        apply_reset();
        set_lane(0, 4);
        bus.nd = 4'b0001;
        tick();
        e0 = edge_cnt;
        set_lane(0, 8);
        tick();
        bus.nd = '0;
        wait_results(2, ok);
        n_vec++;
        if (bus.ovr !== 4'b0000) begin
            n_miss++;
            $display("FAIL collide_ovr: got %b want 0000", bus.ovr);
        end
        n_vec++;
        if (!ok) begin
            n_miss++;
            $display("FAIL collide_count: got %0d results want 2", res_q.size());
        end
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (k >= res_q.size()) begin
                n_miss++;
                $display("FAIL collide[%0d]: no result, want ch0 dat %0d", k, expd[k]);
            end else if (res_q[k].ch !== 3'd0 || res_q[k].dat !== OW'(expd[k]) ||
                         res_q[k].edge_no != e0 + 4 * (k + 1)) begin
                n_miss++;
                $display("FAIL collide[%0d]: got ch%0d dat %0d @E+%0d, want ch0 dat %0d @E+%0d",
                         k, res_q[k].ch, $signed(res_q[k].dat), res_q[k].edge_no - e0,
                         expd[k], 4 * (k + 1));
            end
        end
    endtask

    task automatic test_sign_floor();
        longint xin[3];
        longint expd[3];
        bit     ok;
        xin[0]  = -(longint'(1) << 43);
        xin[1]  = 0;
        xin[2]  = 0;
        expd[0] = -(longint'(1) << 41);
        expd[1] = 3 * (longint'(1) << 42);
        expd[2] = -(longint'(1) << 41);

        apply_reset();
        set_lane(3, -1);
        bus.nd = 4'b1000;
        tick();
        bus.nd = '0;
        wait_results(1, ok);
        n_vec++;
        if (!ok || res_q[0].ch !== 3'd3 || res_q[0].dat !== {OW{1'b1}}) begin
            n_miss++;
            if (res_q.size() == 0)
                $display("FAIL floor_minus1: no result, want ch3 dat -1");
            else
                $display("FAIL floor_minus1: got ch%0d dat %0d (n=%0d), want ch3 dat -1",
                         res_q[0].ch, $signed(res_q[0].dat), res_q.size());
        end

        apply_reset();
        for (int k = 0; k < 3; k++) begin
            set_lane(3, xin[k]);
            bus.nd = 4'b1000;
            tick();
            bus.nd = '0;
            repeat (7) tick();
        end
        wait_results(3, ok);
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (k >= res_q.size()) begin
                n_miss++;
                $display("FAIL extreme[%0d]: no result, want ch3 dat %0d", k, expd[k]);
            end else if (res_q[k].ch !== 3'd3 || res_q[k].dat !== OW'(expd[k])) begin
                n_miss++;
                $display("FAIL extreme[%0d]: got ch%0d dat %0d, want ch3 dat %0d",
                         k, res_q[k].ch, $signed(res_q[k].dat), expd[k]);
            end
        end
    endtask

    // ch0 strobes every 5 clocks (as fast as it can go without overrunning
    // while another channel shares the datapath); ch2 strobes once.
    task automatic test_fairness();
        logic [2:0]  exp_ch[5]   = '{3'd0, 3'd2, 3'd0, 3'd0, 3'd0};
        longint      expd[5]     = '{1, 10, -4, -8, -12};
        int unsigned e0;
        bit          ok;
        apply_reset();
        for (int k = 0; k < 20; k++) begin
            bus.nd = '0;
            if (k % 5 == 0) begin
                set_lane(0, 4 * (k / 5 + 1));
                bus.nd[0] = 1'b1;
            end
            if (k == 0) begin
                set_lane(2, 40);
                bus.nd[2] = 1'b1;
            end
            tick();
            if (k == 0) e0 = edge_cnt;
        end
        bus.nd = '0;
        wait_results(5, ok);
        n_vec++;
        if (!ok) begin
            n_miss++;
            $display("FAIL fair_count: got %0d results want 5", res_q.size());
        end
        for (int k = 0; k < 5; k++) begin
            n_vec++;
            if (k >= res_q.size()) begin
                n_miss++;
                $display("FAIL fair[%0d]: no result, want ch%0d dat %0d", k, exp_ch[k], expd[k]);
            end else if (res_q[k].ch !== exp_ch[k] || res_q[k].dat !== OW'(expd[k]) ||
                         res_q[k].edge_no != e0 + 4 * (k + 1)) begin
                n_miss++;
                $display("FAIL fair[%0d]: got ch%0d dat %0d @E+%0d, want ch%0d dat %0d @E+%0d",
                         k, res_q[k].ch, $signed(res_q[k].dat), res_q[k].edge_no - e0,
                         exp_ch[k], expd[k], 4 * (k + 1));
            end
        end
        n_vec++;
        if (bus.ovr !== 4'b0000) begin
            n_miss++;
            $display("FAIL fair_ovr: got %b want 0000", bus.ovr);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.nd  = '0;
        bus.din = '0;
        test_reset();
        test_impulse();
        test_simultaneous();
        test_overrun();
        test_reset_mid_op();
        test_grant_collision();
        test_sign_floor();
        test_fairness();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
